// File: rtl/mips_encoder_pkg.sv
// Shared types and MIPS64 opcode/funct constants for the instruction encoder.
package mips_encoder_pkg;

  typedef enum logic [3:0] {
    ENC_NOP,
    ENC_ADDU,
    ENC_ADDIU,
    ENC_ORI,
    ENC_LUI,
    ENC_SLL,
    ENC_DSLL,
    ENC_LW,
    ENC_SW,
    ENC_BEQ,
    ENC_J,
    ENC_MOVE,
    ENC_LI32,
    ENC_LI64
  } enc_op_t;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] OP0_SLL    = 6'h00;
  localparam logic [5:0] OP0_ADDU   = 6'h21;
  localparam logic [5:0] OP0_DSLL   = 6'h38;

  localparam logic [3:0] ENC_LAST_LEGAL = 4'd13;

  // Index of the final word of a request (word count minus one).
  function automatic logic [2:0] last_idx(
    input enc_op_t     op,
    input logic [31:0] imm
  );
    logic [2:0] idx;
    idx = 3'd0;
    if (op == ENC_LI64) idx = 3'd5;
    if (op == ENC_LI32 && imm[31:16] != 16'h0 && imm[15:0] != 16'h0)
      idx = 3'd1;
    return idx;
  endfunction

endpackage

// File: rtl/mips_inst_pack.sv
// Combinational R/I/J field packer for 32-bit MIPS instruction words.
module mips_inst_pack
  import mips_encoder_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] inst
);

  always_comb begin
    unique case (fmt)
      FMT_I:   inst = {opcode, rs, rt, imm16};
      FMT_J:   inst = {opcode, target26};
      default: inst = {opcode, rs, rt, rd, shamt, funct};
    endcase
  end

endmodule

// File: rtl/mips_encoder.sv
// Request-to-instruction encoder: expands ops and pseudo-ops into a
// valid/ready stream of MIPS64 instruction words.
module mips_encoder
  import mips_encoder_pkg::*;
#(
  parameter int IMM_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [4:0]       req_rs,
  input  logic [4:0]       req_rt,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_shamt,
  input  logic [IMM_W-1:0] req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_last,
  output logic             out_err,
  output logic             busy
);

  state_t      state_q, state_d;
  enc_op_t     op_q, op_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d;
  logic [4:0]  rd_q, rd_d, sh_q, sh_d;
  logic [63:0] imm_q, imm_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  lidx_q, lidx_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_last_q, out_last_d;
  logic        err_q, err_d;

  logic        accept, fire, legal;
  enc_op_t     req_op_e;
  logic [63:0] req_imm64;

  enc_op_t     g_op;
  logic [4:0]  g_rs, g_rt, g_rd, g_sh;
  logic [63:0] g_imm;
  logic [2:0]  g_step;

  fmt_t        p_fmt;
  logic [5:0]  p_opc, p_fn;
  logic [4:0]  p_rs, p_rt, p_rd, p_sh;
  logic [15:0] p_imm16;
  logic [31:0] word;

  assign req_op_e  = enc_op_t'(req_op);
  assign req_imm64 = 64'(req_imm);
  assign legal     = req_op <= ENC_LAST_LEGAL;

  assign req_ready = (state_q == ST_IDLE) && !out_valid_q
                   && !reset && !flush;
  assign accept    = req_valid && req_ready;
  assign fire      = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_last  = out_last_q;
  assign out_err   = err_q;
  assign busy      = state_q == ST_EMIT;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && legal) state_d = ST_EMIT;
      ST_EMIT: if (fire && out_last_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // The word generator sees the live request on accept, else the next step.
  always_comb begin
    g_op   = accept ? req_op_e  : op_q;
    g_rs   = accept ? req_rs    : rs_q;
    g_rt   = accept ? req_rt    : rt_q;
    g_rd   = accept ? req_rd    : rd_q;
    g_sh   = accept ? req_shamt : sh_q;
    g_imm  = accept ? req_imm64 : imm_q;
    g_step = accept ? 3'd0      : step_q + 3'd1;
  end

  always_comb begin
    p_fmt   = FMT_R;
    p_opc   = OP_SPECIAL;
    p_rs    = '0;
    p_rt    = '0;
    p_rd    = '0;
    p_sh    = '0;
    p_fn    = '0;
    p_imm16 = g_imm[15:0];
    unique case (g_op)
      ENC_ADDU: begin
        p_rs = g_rs; p_rt = g_rt; p_rd = g_rd; p_fn = OP0_ADDU;
      end
      ENC_MOVE: begin
        p_rs = g_rs; p_rd = g_rd; p_fn = OP0_ADDU;
      end
      ENC_SLL: begin
        p_rt = g_rt; p_rd = g_rd; p_sh = g_sh; p_fn = OP0_SLL;
      end
      ENC_DSLL: begin
        p_rt = g_rt; p_rd = g_rd; p_sh = g_sh; p_fn = OP0_DSLL;
      end
      ENC_ADDIU: begin
        p_fmt = FMT_I; p_opc = OP_ADDIU; p_rs = g_rs; p_rt = g_rt;
      end
      ENC_ORI: begin
        p_fmt = FMT_I; p_opc = OP_ORI; p_rs = g_rs; p_rt = g_rt;
      end
      ENC_LW: begin
        p_fmt = FMT_I; p_opc = OP_LW; p_rs = g_rs; p_rt = g_rt;
      end
      ENC_SW: begin
        p_fmt = FMT_I; p_opc = OP_SW; p_rs = g_rs; p_rt = g_rt;
      end
      ENC_BEQ: begin
        p_fmt = FMT_I; p_opc = OP_BEQ; p_rs = g_rs; p_rt = g_rt;
      end
      ENC_LUI: begin
        p_fmt = FMT_I; p_opc = OP_LUI; p_rt = g_rt;
      end
      ENC_J: begin
        p_fmt = FMT_J; p_opc = OP_J;
      end
      ENC_LI32: begin
        p_fmt = FMT_I;
        p_rt  = g_rt;
        if (g_step == 3'd0 && g_imm[31:16] != 16'h0) begin
          p_opc   = OP_LUI;
          p_imm16 = g_imm[31:16];
        end else begin
          p_opc = OP_ORI;
          p_rs  = (g_step == 3'd0) ? 5'd0 : g_rt;
        end
      end
      ENC_LI64: begin
        p_fmt = FMT_I;
        p_opc = OP_ORI;
        p_rs  = g_rt;
        p_rt  = g_rt;
        unique case (g_step)
          3'd0: begin
            p_opc = OP_LUI; p_rs = '0; p_imm16 = g_imm[63:48];
          end
          3'd1: p_imm16 = g_imm[47:32];
          3'd2, 3'd4: begin
            p_fmt = FMT_R; p_opc = OP_SPECIAL; p_rs = '0;
            p_rd = g_rt; p_sh = 5'd16; p_fn = OP0_DSLL;
          end
          3'd3: p_imm16 = g_imm[31:16];
          default: p_imm16 = g_imm[15:0];
        endcase
      end
      default: ;
    endcase
  end

  mips_inst_pack u_pack (
    .fmt      (p_fmt),
    .opcode   (p_opc),
    .rs       (p_rs),
    .rt       (p_rt),
    .rd       (p_rd),
    .shamt    (p_sh),
    .funct    (p_fn),
    .imm16    (p_imm16),
    .target26 (g_imm[25:0]),
    .inst     (word)
  );

  always_comb begin
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    sh_d        = sh_q;
    imm_d       = imm_q;
    step_d      = step_q;
    lidx_d      = lidx_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    if (accept) begin
      op_d   = req_op_e;
      rs_d   = req_rs;
      rt_d   = req_rt;
      rd_d   = req_rd;
      sh_d   = req_shamt;
      imm_d  = req_imm64;
      step_d = 3'd0;
      lidx_d = last_idx(req_op_e, req_imm64[31:0]);
      if (legal) begin
        out_valid_d = 1'b1;
        out_inst_d  = word;
        out_last_d  = last_idx(req_op_e, req_imm64[31:0]) == 3'd0;
      end else begin
        err_d = 1'b1;
      end
    end else if (fire) begin
      if (out_last_q) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        step_d      = 3'd0;
      end else begin
        step_d     = step_q + 3'd1;
        out_inst_d = word;
        out_last_d = (step_q + 3'd1) == lidx_q;
      end
    end
    if (flush) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      step_d      = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= ENC_NOP;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      sh_q        <= '0;
      imm_q       <= '0;
      step_q      <= '0;
      lidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      sh_q        <= sh_d;
      imm_q       <= imm_d;
      step_q      <= step_d;
      lidx_q      <= lidx_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mips_encoder.sv
// Bench for mips_encoder: directed cases plus random requests checked
// against a word-list model built from the instruction formats.
module tb_mips_encoder;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [63:0] req_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_last, out_err, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] seen[$];

  always #5 clk = ~clk;

  mips_encoder #(.IMM_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs    (req_rs),
    .req_rt    (req_rt),
    .req_rd    (req_rd),
    .req_shamt (req_shamt),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rw(input int rs, input int rt,
                                     input int rd, input int sh,
                                     input int fn);
    return 32'((rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
  endfunction

  function automatic logic [31:0] iw(input int opc, input int rs,
                                     input int rt, input longint imm);
    return 32'((opc << 26) + (rs << 21) + (rt << 16) + (imm & 'hffff));
  endfunction

  // Expected word list for one request, straight from the op definitions.
  function automatic void build(input int op, input int rs, input int rt,
                                input int rd, input int sh,
                                input logic [63:0] imm);
    longint hi, lo, v;
    v  = longint'(imm);
    hi = (v >> 16) & 'hffff;
    lo = v & 'hffff;
    exp_q.delete();
    case (op)
      0:  exp_q.push_back(32'h0);
      1:  exp_q.push_back(rw(rs, rt, rd, 0, 'h21));
      2:  exp_q.push_back(iw('h09, rs, rt, v));
      3:  exp_q.push_back(iw('h0d, rs, rt, v));
      4:  exp_q.push_back(iw('h0f, 0, rt, v));
      5:  exp_q.push_back(rw(0, rt, rd, sh, 'h00));
      6:  exp_q.push_back(rw(0, rt, rd, sh, 'h38));
      7:  exp_q.push_back(iw('h23, rs, rt, v));
      8:  exp_q.push_back(iw('h2b, rs, rt, v));
      9:  exp_q.push_back(iw('h04, rs, rt, v));
      10: exp_q.push_back(32'((2 << 26) + (v & 'h3ffffff)));
      11: exp_q.push_back(rw(rs, 0, rd, 0, 'h21));
      12: begin
        if (hi == 0) exp_q.push_back(iw('h0d, 0, rt, lo));
        else if (lo == 0) exp_q.push_back(iw('h0f, 0, rt, hi));
        else begin
          exp_q.push_back(iw('h0f, 0, rt, hi));
          exp_q.push_back(iw('h0d, rt, rt, lo));
        end
      end
      13: begin
        exp_q.push_back(iw('h0f, 0, rt, (v >> 48) & 'hffff));
        exp_q.push_back(iw('h0d, rt, rt, (v >> 32) & 'hffff));
        exp_q.push_back(rw(0, rt, rt, 16, 'h38));
        exp_q.push_back(iw('h0d, rt, rt, hi));
        exp_q.push_back(rw(0, rt, rt, 16, 'h38));
        exp_q.push_back(iw('h0d, rt, rt, lo));
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input int op, input int rs, input int rt,
                            input int rd, input int sh,
                            input logic [63:0] imm);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready", req_ready, 1);
    req_op    = 4'(op);
    req_rs    = 5'(rs);
    req_rt    = 5'(rt);
    req_rd    = 5'(rd);
    req_shamt = 5'(sh);
    req_imm   = imm;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Issue a request and drain its words; stall_w holds ready low 3 cycles.
  task automatic run_req(input int op, input int rs, input int rt,
                         input int rd, input int sh,
                         input logic [63:0] imm, input int stall_pct,
                         input int stall_w);
    int cyc = 0;
    int done = 0;
    int hold = 0;
    build(op, rs, rt, rd, sh, imm);
    seen.delete();
    accept_req(op, rs, rt, rd, sh, imm);
    if (op > 13) begin
      chk("err_pulse", out_err, 1);
      chk("err_valid", out_valid, 0);
      chk("err_busy", busy, 0);
      tick();
      chk("err_clear", out_err, 0);
      chk("err_valid2", out_valid, 0);
      return;
    end
    while (exp_q.size() > 0 && cyc < 300) begin
      chk("valid", out_valid, 1);
      if (!out_valid) break;
      chk("inst", out_inst, exp_q[0]);
      chk("last", out_last, exp_q.size() == 1);
      chk("busy", busy, 1);
      chk("rdy_busy", req_ready, 0);
      if (done == stall_w && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = $urandom_range(0, 99) >= stall_pct;
      end
      if (out_ready) begin
        seen.push_back(out_inst);
        void'(exp_q.pop_front());
        done++;
      end
      tick();
      cyc++;
    end
    chk("drain", exp_q.size(), 0);
    out_ready = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rdy", req_ready, 1);
  endtask

  initial begin
    int op, rt;
    logic [63:0] imm;
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_rs    = '0;
    req_rt    = '0;
    req_rd    = '0;
    req_shamt = '0;
    req_imm   = '0;
    out_ready = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", req_ready, 1);

    run_req(1, 1, 2, 3, 0, 64'h0, 0, -1);
    chk("addu_word", seen[0], 32'h00221821);
    run_req(12, 0, 5, 0, 0, 64'h12345678, 0, -1);
    chk("li32_n", seen.size(), 2);
    chk("li32_w1", seen[1], 32'h34a55678);
    run_req(12, 0, 2, 0, 0, 64'h0000beef, 0, -1);
    chk("li32_lo", seen[0], 32'h3402beef);
    run_req(12, 0, 7, 0, 0, 64'h55aa0000, 0, -1);
    chk("li32_hi_n", seen.size(), 1);
    run_req(13, 0, 4, 0, 0, 64'h0123456789abcdef, 0, -1);
    chk("li64_w2", seen[2], 32'h00042438);
    chk("li64_w5", seen[5], 32'h3484cdef);
    run_req(13, 0, 4, 0, 0, 64'h0123456789abcdef, 0, 2);
    chk("li64s_n", seen.size(), 6);
    chk("li64s_w3", seen[3], 32'h348489ab);

    // Flush while word 2 of an LI64 is presented.
    accept_req(13, 0, 4, 0, 0, 64'h0123456789abcdef);
    out_ready = 1'b1;
    tick();
    chk("fl_w1", out_inst, 32'h34844567);
    flush = 1'b1;
    #1;
    chk("fl_rdy", req_ready, 0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    run_req(3, 0, 1, 0, 0, 64'h00ff, 0, -1);
    chk("fl_ori", seen[0], 32'h340100ff);

    // Reset while word 2 of an LI64 is presented.
    accept_req(13, 0, 4, 0, 0, 64'h0123456789abcdef);
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_inst", out_inst, 0);
    chk("rs_busy", busy, 0);
    run_req(3, 0, 1, 0, 0, 64'h00ff, 0, -1);
    chk("rs_ori", seen[0], 32'h340100ff);

    run_req(15, 0, 0, 0, 0, 64'h0, 0, -1);
    run_req(14, 3, 3, 3, 3, 64'h1, 0, -1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = 14 + $urandom_range(0, 1);
      else op = $urandom_range(0, 13);
      imm = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) imm[31:16] = 16'h0;
      else if ($urandom_range(0, 3) == 0) imm[15:0] = 16'h0;
      rt = $urandom_range(0, 31);
      run_req(op, $urandom_range(0, 31), rt, $urandom_range(0, 31),
              $urandom_range(0, 31), imm, 30, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
